// File: rtl/bcd_xs3_codec_seq.sv
// Serial multi-digit BCD <-> excess-3 converter, one digit per clock, LSD first.
// Optional saturating error-word counter (err_cnt) enabled by defining BCDX_ERR_CNT_EN.
module bcd_xs3_codec_seq #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_mode,
    input  logic [4*DIGITS-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_data,
    output logic [DIGITS-1:0]     out_err_mask,
    output logic                  out_err,
    output logic                  busy
`ifdef BCDX_ERR_CNT_EN
    ,
    output logic [CNT_W-1:0]      err_cnt
`endif
);

    localparam int unsigned DATA_W = 4 * DIGITS;
    localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    if ((DIGITS < 1) || (DIGITS > 16) || (CNT_W < 1)) begin : g_param_check
        $error("bcd_xs3_codec_seq: DIGITS must be 1..16 and CNT_W >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IDX_W-1:0]    r_idx;
    logic                r_mode;
    logic [DATA_W-1:0]   r_in_data;
    logic [DATA_W-1:0]   r_out_data;
    logic [DIGITS-1:0]   r_err_mask;
    logic                r_out_err;
    logic                r_out_valid;
    logic                r_in_ready;
    logic                r_busy;

    logic                w_in_fire;
    logic                w_out_fire;
    logic                w_last;
    logic [3:0]          w_digit_in;
    logic [3:0]          w_digit_out;
    logic                w_digit_err;
    logic                w_out_valid_nxt;
    logic                w_in_ready_nxt;
    logic                w_busy_nxt;

    assign w_in_fire  = in_valid && r_in_ready;
    assign w_out_fire = r_out_valid && out_ready;
    assign w_last     = (r_idx == IDX_W'(DIGITS - 1));
    assign w_digit_in = r_in_data[4*r_idx +: 4];

    // Per-digit rule; out-of-range codes are flagged and forced to 4'hF rather than wrapped.
    always_comb begin
        w_digit_out = 4'hF;
        w_digit_err = 1'b1;
        if (!r_mode) begin
            if (w_digit_in <= 4'd9) begin
                w_digit_out = w_digit_in + 4'd3;
                w_digit_err = 1'b0;
            end
        end else begin
            if ((w_digit_in >= 4'd3) && (w_digit_in <= 4'd12)) begin
                w_digit_out = w_digit_in - 4'd3;
                w_digit_err = 1'b0;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_in_fire)  w_state_nxt = S_CONV;
            S_CONV:  if (w_last)     w_state_nxt = S_DONE;
            S_DONE:  if (w_out_fire) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        w_out_valid_nxt = (w_state_nxt == S_DONE);
        w_in_ready_nxt  = (w_state_nxt == S_IDLE);
        w_busy_nxt      = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    // Word capture and digit-serial accumulation of the result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx      <= '0;
            r_mode     <= 1'b0;
            r_in_data  <= '0;
            r_out_data <= '0;
            r_err_mask <= '0;
            r_out_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_in_fire) begin
                        r_in_data  <= in_data;
                        r_mode     <= in_mode;
                        r_out_data <= '0;
                        r_err_mask <= '0;
                        r_out_err  <= 1'b0;
                        r_idx      <= '0;
                    end
                end
                S_CONV: begin
                    r_out_data[4*r_idx +: 4] <= w_digit_out;
                    r_err_mask[r_idx]        <= w_digit_err;
                    r_out_err                <= r_out_err | w_digit_err;
                    r_idx                    <= w_last ? '0 : r_idx + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef BCDX_ERR_CNT_EN
    logic [CNT_W-1:0] r_err_cnt;

    // Counts delivered error words; holds at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (w_out_fire && r_out_err && (r_err_cnt != {CNT_W{1'b1}})) begin
            r_err_cnt <= r_err_cnt + CNT_W'(1);
        end
    end

    assign err_cnt = r_err_cnt;
`endif

    assign in_ready     = r_in_ready;
    assign out_valid    = r_out_valid;
    assign out_data     = r_out_data;
    assign out_err_mask = r_err_mask;
    assign out_err      = r_out_err;
    assign busy         = r_busy;

endmodule

// File: tb/tb_bcd_xs3_codec_seq.sv
// Scoreboard bench for bcd_xs3_codec_seq (4 digits); with BCDX_ERR_CNT_EN it uses CNT_W=2.
module tb_bcd_xs3_codec_seq;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned DW     = 4 * DIGITS;
`ifdef BCDX_ERR_CNT_EN
    localparam int unsigned CNT_W  = 2;
`else
    localparam int unsigned CNT_W  = 16;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic              in_mode;
    logic [DW-1:0]     in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_data;
    logic [DIGITS-1:0] out_err_mask;
    logic              out_err;
    logic              busy;
`ifdef BCDX_ERR_CNT_EN
    logic [CNT_W-1:0]  err_cnt;
`endif

    bcd_xs3_codec_seq #(.DIGITS(DIGITS), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_mode      (in_mode),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_err_mask (out_err_mask),
        .out_err      (out_err),
        .busy         (busy)
`ifdef BCDX_ERR_CNT_EN
        ,
        .err_cnt      (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0]     data;
        logic [DIGITS-1:0] mask;
        logic              err;
    } exp_t;

    exp_t sb[$];
    int   n_chk   = 0;
    int   n_pass  = 0;
    int   n_fail  = 0;
    int   exp_cnt = 0;
    int   cnt_max = (1 << CNT_W) - 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic mode, input logic [DW-1:0] d);
        exp_t e;
        e = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            int v;
            v = int'(d[4*i +: 4]) + (mode ? -3 : 3);
            if ((!mode && v <= 12) || (mode && v >= 0 && v <= 9)) begin
                e.data[4*i +: 4] = 4'(v);
            end else begin
                e.data[4*i +: 4] = 4'hF;
                e.mask[i]        = 1'b1;
            end
        end
        e.err = |e.mask;
        return e;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
        exp_cnt = 0;
    endtask

    task automatic send(input logic mode, input logic [DW-1:0] data, input bit chk_lat);
        int k;
        k = 0;
        while (!in_ready && k < 20) begin @(posedge clk); #1; k++; end
        check("send_ready", 64'(in_ready), 64'(1));
        in_valid = 1'b1;
        in_mode  = mode;
        in_data  = data;
        sb.push_back(model(mode, data));
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_mode  = ~mode;
        in_data  = ~data;
        if (chk_lat) begin
            k = 0;
            while (!out_valid && k < 20) begin @(posedge clk); #1; k++; end
            check("latency", 64'(k), 64'(DIGITS));
        end
    endtask

    task automatic recv();
        exp_t e;
        int   k;
        k = 0;
        while (!out_valid && k < 20) begin @(posedge clk); #1; k++; end
        check("recv_valid", 64'(out_valid), 64'(1));
        check("sb_nonempty", 64'(sb.size() > 0), 64'(1));
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check("out_data", 64'(out_data), 64'(e.data));
        check("out_err_mask", 64'(out_err_mask), 64'(e.mask));
        check("out_err", 64'(out_err), 64'(e.err));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        if (e.err && exp_cnt < cnt_max) exp_cnt++;
        check("post_hs_valid", 64'(out_valid), 64'(0));
        check("post_hs_ready", 64'(in_ready), 64'(1));
`ifdef BCDX_ERR_CNT_EN
        check("err_cnt", 64'(err_cnt), 64'(exp_cnt));
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] held;
        bit            saw_valid;
        int            sat_seq [5];
        sat_seq = '{1, 2, 3, 3, 3};

        in_valid  = 1'b0;
        in_mode   = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset / idle state
        do_reset();
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_out_data", 64'(out_data), 64'(0));
        check("rst_err_mask", 64'(out_err_mask), 64'(0));
`ifdef BCDX_ERR_CNT_EN
        check("rst_err_cnt", 64'(err_cnt), 64'(0));
`endif

        // Forward conversion
        send(1'b0, 16'h1290, 1'b1);
        check("fwd_const", 64'(out_data), 64'(16'h45C3));
        check("fwd_busy", 64'(busy), 64'(1));
        recv();

        // Reverse conversion
        send(1'b1, 16'h45C3, 1'b1);
        check("rev_const", 64'(out_data), 64'(16'h1290));
        recv();

        // Forward with one invalid digit
        send(1'b0, 16'h12A9, 1'b1);
        check("inv_const", 64'(out_data), 64'(16'h45FC));
        check("inv_mask_const", 64'(out_err_mask), 64'(4'b0010));
        recv();

        // Backpressure in DONE with a competing in_valid
        send(1'b0, 16'h0987, 1'b1);
        held     = out_data;
        in_valid = 1'b1;
        in_mode  = 1'b1;
        in_data  = 16'h5555;
        repeat (5) begin
            @(posedge clk); #1;
            check("bp_data_stable", 64'(out_data), 64'(held));
            check("bp_in_ready", 64'(in_ready), 64'(0));
            check("bp_out_valid", 64'(out_valid), 64'(1));
        end
        in_valid = 1'b0;
        recv();
        check("bp_idle_busy", 64'(busy), 64'(0));

        // Reverse-mode boundaries: 3,12 valid; 0,13 invalid
        send(1'b1, 16'h3C0D, 1'b1);
        recv();
        // Forward-mode boundaries: 9 valid; 10,15 invalid
        send(1'b0, 16'h9AF0, 1'b1);
        recv();

        // Reset during the second CONV cycle
        send(1'b0, 16'h4321, 1'b0);
        @(posedge clk); #1;
        check("mid_busy", 64'(busy), 64'(1));
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb.delete();
        exp_cnt = 0;
        check("mid_rst_in_ready", 64'(in_ready), 64'(1));
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_out_data", 64'(out_data), 64'(0));
        saw_valid = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid) saw_valid = 1'b1;
        end
        check("mid_no_valid", 64'(saw_valid), 64'(0));
        send(1'b0, 16'h8765, 1'b1);
        recv();

`ifdef BCDX_ERR_CNT_EN
        // Counter saturation at 2^CNT_W-1
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send(1'b0, 16'hFFFF, 1'b1);
            recv();
            check("sat_seq", 64'(err_cnt), 64'(sat_seq[i]));
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bcd_xs3_codec_seq.md
Name: bcd_xs3_codec_seq

Overview:
- Multi-digit, bidirectional BCD <-> excess-3 code converter. Successor to the single-digit combinational BCD-to-XS3 converter.
- Processes one 4-bit digit per clock, least-significant digit (LSD) first, through a serial digit engine.
- Uses valid/ready handshakes on both input and output.
- Flags invalid digits per position instead of emitting undefined values. Sits between the BCD display/arithmetic datapath and the XS3 arithmetic units.

Parameters:
- DIGITS, 4, number of 4-bit digits per word (legal range 1..16).
- CNT_W, 16, width of the optional error-word counter.

Ports:
- clk, input, 1, single clock; all state updates on rising edge.
- rst_n, input, 1, synchronous active-low reset, sampled on rising edge of clk.
- in_valid, input, 1, input word valid.
- in_ready, output, 1, block can accept a word.
- in_mode, input, 1, 0 = BCD->XS3 (+3 per digit), 1 = XS3->BCD (-3 per digit).
- in_data, input, 4*DIGITS, packed digits; digit i = in_data[4i+3:4i].
- out_valid, output, 1, result word valid.
- out_ready, input, 1, downstream accepts result.
- out_data, output, 4*DIGITS, converted digits, same packing as in_data.
- out_err_mask, output, DIGITS, bit i = 1 if input digit i was invalid.
- out_err, output, 1, OR-reduction of out_err_mask.
- busy, output, 1, high in CONV or DONE.
- err_cnt, output, CNT_W, present only with BCDX_ERR_CNT_EN.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State <= IDLE; out_data, out_err_mask and the digit index <= 0.
  - out_valid=0, in_ready=1, busy=0.
  - Synchronous reset overrides everything, including an in-flight word, which is discarded without a response.
- FSM state IDLE:
  - in_ready=1.
  - On in_valid && in_ready at an edge: latch in_data and in_mode; clear the out_data/out_err_mask accumulators; idx <= 0; go to CONV.
- FSM state CONV:
  - in_ready=0, busy=1.
  - Each edge converts digit idx and writes it to out_data[4idx+:4] and out_err_mask[idx].
  - idx increments each edge. After the edge that processes idx = DIGITS-1, go to DONE.
- FSM state DONE:
  - out_valid=1; out_data and out_err_mask are held stable.
  - On out_valid && out_ready at an edge: go to IDLE, out_valid <= 0.
  - in_ready rises the cycle after the output handshake; there is no same-cycle bypass.
- Latency: out_valid is high DIGITS cycles after the input-handshake edge. Throughput: one word per DIGITS+2 cycles minimum.
- Digit rule, mode 0 (BCD->XS3):
  - d in 0..9: out = d+3, err=0.
  - d in 10..15: out = 4'hF, err=1.
- Digit rule, mode 1 (XS3->BCD):
  - d in 3..12: out = d-3, err=0.
  - d in 0..2 or 13..15: out = 4'hF, err=1.
- Arithmetic is 4-bit, with no carry between digits; invalid digits never wrap.
- Input handshake: in_valid while not in_ready is ignored (no latch). in_data and in_mode changes during CONV do not affect the result.
- Output handshake: out_ready while not out_valid has no effect. out_ready may be held high permanently.
- DIGITS=1: CONV lasts exactly one cycle.

Optional Feature:
- Macro: BCDX_ERR_CNT_EN.
- Defined:
  - err_cnt port exists; reset value 0.
  - Increments by 1 on each output handshake with out_err=1.
  - Saturates at 2^CNT_W-1 (no wrap).
  - Cleared only by reset.
- Undefined: err_cnt port and counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset/idle: rst_n=0 for 2 cycles, then 1 -> out_valid=0, in_ready=1, busy=0, out_data=0; err_cnt=0 if enabled.
- Forward conversion: DIGITS=4, mode 0, in_data=16'h1290 -> out_data=16'h45C3, out_err_mask=4'b0000, out_valid exactly 4 cycles after accept.
- Reverse conversion with invalid digit: mode 1, in_data=16'h45C3 -> 16'h1290. Then mode 0, in_data=16'h12A9 -> out_data=16'h45FC, out_err_mask=4'b0010, out_err=1; err_cnt=1 if enabled.
- Backpressure: out_ready=0 for 5 cycles in DONE -> out_data stable, in_ready=0, a new in_valid is not accepted. Then out_ready=1 -> handshake, and in_ready=1 on the next cycle.
- Reset mid-operation: assert rst_n=0 on the 2nd CONV cycle -> IDLE on the next edge, out_valid never rises, the next word converts correctly.
- Saturation (macro defined, CNT_W=2): 5 consecutive error words -> err_cnt sequence 1,2,3,3,3.
